// File: rtl/sha1_pkg.sv
// Shared constants, FSM state type and the rotate helper for the SHA-1 message scheduler.
package sha1_pkg;

    localparam int WORD_W      = 32;
    localparam int BLOCK_WORDS = 16;
    localparam int N_ROUNDS    = 80;
    localparam int PTR_W       = 4;
    localparam int ROUND_W     = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [WORD_W-1:0] rotl1(input logic [WORD_W-1:0] x);
        return {x[WORD_W-2:0], x[WORD_W-1]};
    endfunction

endpackage

// File: rtl/sha1_w_scheduler_if.sv
// Sequencer-side load bus and round-datapath stream of the SHA-1 scheduler.
// err_o exists only when SHA1_LOAD_CHECK_EN is defined.
interface sha1_w_scheduler_if;
    import sha1_pkg::*;

    logic                load_i;
    logic [WORD_W-1:0]   data_i;
    logic                start_i;
    logic [WORD_W-1:0]   w_o;
    logic                w_valid_o;
    logic                w_ready_i;
    logic [ROUND_W-1:0]  round_o;
    logic                busy_o;
    logic                done_o;
`ifdef SHA1_LOAD_CHECK_EN
    logic                err_o;

    modport slave (
        input  load_i, data_i, start_i, w_ready_i,
        output w_o, w_valid_o, round_o, busy_o, done_o, err_o
    );
    modport master (
        output load_i, data_i, start_i, w_ready_i,
        input  w_o, w_valid_o, round_o, busy_o, done_o, err_o
    );
`else
    modport slave (
        input  load_i, data_i, start_i, w_ready_i,
        output w_o, w_valid_o, round_o, busy_o, done_o
    );
    modport master (
        output load_i, data_i, start_i, w_ready_i,
        input  w_o, w_valid_o, round_o, busy_o, done_o
    );
`endif

endinterface

// File: rtl/sha1_w_buffer.sv
// 16x32 circular word buffer: one write port, four combinational read ports, async clear.
module sha1_w_buffer
    import sha1_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         we_i,
    input  logic [PTR_W-1:0]             waddr_i,
    input  logic [WORD_W-1:0]            wdata_i,
    input  logic [3:0][PTR_W-1:0]        raddr_i,
    output logic [3:0][WORD_W-1:0]       rdata_o
);

    logic [WORD_W-1:0] mem_q [BLOCK_WORDS];

    // NOTE: this memory is cleared on reset because downstream sees defined words even
    // if start arrives before a full block is loaded; that forces flops, not a RAM macro.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < BLOCK_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < 4; p++) begin
            rdata_o[p] = mem_q[raddr_i[p]];
        end
    end

endmodule

// File: rtl/sha1_w_scheduler.sv
// SHA-1 message scheduler: captures a 16-word block, then streams W[0..79] under valid/ready.
// Optional load-count checking with err_o is enabled by SHA1_LOAD_CHECK_EN.
module sha1_w_scheduler
    import sha1_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    sha1_w_scheduler_if.slave bus
);

    localparam logic [ROUND_W-1:0] FIRST_EXP_T = ROUND_W'(BLOCK_WORDS);
    localparam logic [ROUND_W-1:0] LAST_T      = ROUND_W'(N_ROUNDS - 1);
    localparam logic [PTR_W:0]     FULL_CNT    = (PTR_W + 1)'(BLOCK_WORDS);

    state_e             state_q, state_d;
    logic [ROUND_W-1:0] t_q, t_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     load_cnt_q, load_cnt_d;
`ifdef SHA1_LOAD_CHECK_EN
    logic               err_q, err_d;
`endif

    logic                  we;
    logic [PTR_W-1:0]      waddr;
    logic [WORD_W-1:0]     wdata;
    logic [PTR_W-1:0]      t_lo;
    logic [3:0][PTR_W-1:0] raddr;
    logic [3:0][WORD_W-1:0] rdata;
    logic [WORD_W-1:0]     w_cur;

    // Read ports: [0]=t-3, [1]=t-8, [2]=t-14, [3]=t-16 which aliases t in a 16-entry ring.
    assign t_lo  = t_q[PTR_W-1:0];
    assign raddr = {t_lo, t_lo - 4'd14, t_lo - 4'd8, t_lo - 4'd3};

    sha1_w_buffer u_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_comb begin
        w_cur = '0;
        if (state_q == RUN) begin
            w_cur = (t_q < FIRST_EXP_T) ? rdata[3]
                                        : rotl1(rdata[0] ^ rdata[1] ^ rdata[2] ^ rdata[3]);
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        wr_ptr_d   = wr_ptr_q;
        load_cnt_d = load_cnt_q;
        we         = 1'b0;
        waddr      = wr_ptr_q;
        wdata      = bus.data_i;
`ifdef SHA1_LOAD_CHECK_EN
        err_d      = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.load_i) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (load_cnt_q != FULL_CNT) begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
`ifdef SHA1_LOAD_CHECK_EN
                    err_d = (load_cnt_q == FULL_CNT);
`endif
                end else if (bus.start_i) begin
                    t_d = '0;
`ifdef SHA1_LOAD_CHECK_EN
                    if (load_cnt_q != FULL_CNT) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
`else
                    state_d = RUN;
`endif
                end
            end
            RUN: begin
                if (bus.w_ready_i) begin
                    // Expanded words replace the oldest slot so the ring always holds W[t-15..t].
                    we    = (t_q >= FIRST_EXP_T);
                    waddr = t_lo;
                    wdata = w_cur;
                    if (t_q == LAST_T) begin
                        state_d = DONE;
                        t_d     = '0;
                    end else begin
                        t_d = t_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                t_d        = '0;
                wr_ptr_d   = '0;
                load_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            t_q        <= '0;
            wr_ptr_q   <= '0;
            load_cnt_q <= '0;
`ifdef SHA1_LOAD_CHECK_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            wr_ptr_q   <= wr_ptr_d;
            load_cnt_q <= load_cnt_d;
`ifdef SHA1_LOAD_CHECK_EN
            err_q      <= err_d;
`endif
        end
    end

    assign bus.w_o       = w_cur;
    assign bus.w_valid_o = (state_q == RUN);
    assign bus.busy_o    = (state_q != IDLE);
    assign bus.done_o    = (state_q == DONE);
    assign bus.round_o   = t_q;
`ifdef SHA1_LOAD_CHECK_EN
    assign bus.err_o     = err_q;
`endif

endmodule

// File: doc/sha1_w_scheduler.md
Name: sha1_w_scheduler

Overview:
- Receiving end of the 32-bit word-serial block interface driven by the block sequencer.
- Captures 16 words strobed by load_i into a 16x32 circular buffer.
- On start_i, streams the 80 SHA-1 message-schedule words W[0..79] to the round datapath under a valid/ready handshake, then pulses done_o.
- Sits between the sequencer and the SHA-1 compression rounds.

Parameters:
- WORD_W, 32, word width; only 32 is supported.
- N_ROUNDS, 80, number of schedule words emitted per block.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- load_i  in  1  word strobe; data_i is captured on each cycle it is high.
- data_i  in  32  incoming word. The first word received is W[0] (sequencer data word 15).
- start_i  in  1  begin expansion; sampled in IDLE.
- w_o  out  32  current schedule word W[round_o].
- w_valid_o  out  1  w_o is valid.
- w_ready_i  in  1  consumer accepts w_o.
- round_o  out  7  current index t, range 0..79.
- busy_o  out  1  high in RUN and DONE.
- done_o  out  1  one-cycle pulse after W[79] is accepted.

Behaviour:
- Reset (async, rst_i=1), all outputs defined:
  - state=IDLE; wr_ptr=0; load_cnt=0; t=0.
  - w_valid_o=0, busy_o=0, done_o=0, round_o=0.
  - w_o=0 (forced to 0 outside RUN); buffer contents cleared to 0.
- State IDLE:
  - load_i=1: buf[wr_ptr]<=data_i; wr_ptr<=wr_ptr+1 (mod 16); load_cnt saturates at 16.
  - More than 16 loads: wr_ptr wraps and the newest words overwrite the oldest. The start still reads W[0] from buf[0].
  - load_i=1 and start_i=1 in the same cycle: the load wins and start_i is ignored that cycle.
  - start_i=1 and load_i=0: go to RUN with t=0. start_i is level-sensitive.
- State RUN:
  - w_valid_o=1.
  - For t<16: w_o=buf[t].
  - For t>=16: w_o = rotl1(buf[(t-3)&15] ^ buf[(t-8)&15] ^ buf[(t-14)&15] ^ buf[t&15]).
  - w_o is combinational from buffer and t, so W[t] is valid in the same cycle the state/t register updates.
  - Handshake fires when w_valid_o=1 and w_ready_i=1:
    - if t>=16, buf[t&15]<=w_o;
    - t<=t+1.
  - With w_ready_i=0: t, w_o and the buffer are held stable.
  - Handshake at t=79: go to DONE.
  - load_i and start_i are ignored in RUN.
- State DONE:
  - One cycle: done_o=1, w_valid_o=0.
  - Next state IDLE, with load_cnt=0, wr_ptr=0, t=0.
  - The buffer is not cleared, but its contents are overwritten by the next 16 loads.
- Throughput: 80 cycles from RUN entry to the last handshake when w_ready_i is held at 1. done_o asserts on cycle 81.
- Reset asserted mid-RUN: immediate return to IDLE. Any partial output is discarded, and done_o is never asserted.
- round_o mirrors t at all times.

Optional Feature:
- Macro: SHA1_LOAD_CHECK_EN.
- Defined:
  - Adds output err_o (1 bit, reset 0).
  - start_i in IDLE with load_cnt!=16: stay in IDLE, set err_o=1 sticky.
  - err_o clears on the next load_i or on reset.
  - A load_i while load_cnt==16 (overrun) also sets err_o.
- Not defined:
  - No err_o port.
  - start_i proceeds regardless of load_cnt.

Decomposition:
- Package sha1_pkg:
  - WORD_W=32, BLOCK_WORDS=16, N_ROUNDS=80.
  - State enum {IDLE, RUN, DONE}.
  - rotl1 function.
- Sub-module sha1_w_buffer:
  - 16x32 register file.
  - One write port and four combinational read ports (t-3, t-8, t-14, t-16, all mod 16).
  - Async active-high clear.
- The top level holds the FSM, counters and XOR/rotate logic.

Test Plan:
- "abc" block: load 0x61626380, then 14 x 0x00000000, then 0x00000018; start with ready=1 -> W0=0x61626380, W15=0x18, W16=0xC2C4C700, W17=0x0, W18=0x30, W19=0x85898E01; done_o pulses on cycle 81 after start.
- Backpressure: drop w_ready_i for 3 cycles at t=20 -> round_o holds at 20, w_o is stable, the final sequence is identical to the no-stall run, and done_o is delayed by 3 cycles.
- Reset at t=40: assert rst_i -> w_valid_o=0, round_o=0, no done_o. Reload and restart -> correct W sequence.
- Simultaneous load_i and start_i in IDLE -> word is captured and no transition occurs; start on the next cycle -> RUN.
- Overflow: 18 loads (values 1..18), then start -> W0=17, W1=18, W2=3.
- With SHA1_LOAD_CHECK_EN: start after 10 loads -> err_o=1 and state stays IDLE. The next load clears err_o; after 16 loads total, start enters RUN.
